// File: rtl/edge_stream_packer_if.sv
// Byte-stream handshake between the edge packer and its downstream consumer.
// The producer drives valid/byte/last and the consumer returns ready.
interface edge_stream_packer_if;
  logic       o_valid;
  logic [7:0] o_byte;
  logic       o_last;
  logic       i_ready;

  modport master (output o_valid, output o_byte, output o_last, input i_ready);
  modport slave  (input o_valid, input o_byte, input o_last, output i_ready);
endinterface

// File: rtl/edge_stream_packer.sv
// Binarises one frame of edge pixels, packs 8 per byte MSB-first with per-row padding,
// and streams the bytes through a first-word-fall-through FIFO to a valid/ready consumer.
//
// state   | meaning
// IDLE    | waiting for i_start, pixels ignored
// CAPTURE | binarising and packing pixels of the armed frame
// DRAIN   | frame packed, waiting for the pending byte and FIFO to empty
module edge_stream_packer #(
  parameter int H_RES      = 170,
  parameter int V_RES      = 240,
  parameter int EDGE_TH    = 128,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_de,
  input  logic [7:0]           i_data,
  edge_stream_packer_if.master bus,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overflow
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0]    TH       = 9'(EDGE_TH);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic [7:0]    byte_nxt;
  logic          pend;
  logic [8:0]    pend_data;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [8:0]    rd_word;

  logic start_ok, pix, pix_bit, col_end, row_end, emit, frame_end;
  logic fifo_rd, fifo_wr, fifo_empty;

  assign start_ok  = (state == IDLE) && i_start;
  assign pix       = (state == CAPTURE) && i_de;
  assign pix_bit   = {1'b0, i_data} >= TH;
  assign col_end   = (col == COL_LAST);
  assign row_end   = (row == ROW_LAST);
  assign emit      = pix && ((bit_cnt == 3'd7) || col_end);
  assign frame_end = pix && col_end && row_end;

  always_comb begin
    byte_nxt = sr;
    byte_nxt[3'd7 - bit_cnt] = pix_bit;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = CAPTURE;
      CAPTURE: if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (!pend && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state != IDLE);
    o_frame_done = (state == DRAIN) && !pend && fifo_empty;
  end

  // ---------------- pixel packing ----------------
  // Completed bytes wait one cycle in pend before entering the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      pend <= emit;
      if (start_ok) begin
        col     <= '0;
        row     <= '0;
        bit_cnt <= '0;
        sr      <= '0;
      end else if (pix) begin
        if (emit) begin
          sr        <= '0;
          bit_cnt   <= '0;
          pend_data <= {col_end && row_end, byte_nxt};
        end else begin
          sr      <= byte_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // ---------------- byte FIFO ----------------
  assign fifo_empty = (count == '0);
  assign fifo_rd    = !fifo_empty && bus.i_ready;
  // A full FIFO still takes a write when the head is leaving the same cycle.
  assign fifo_wr    = pend && ((count != FULL_CNT) || fifo_rd);
  assign rd_word    = mem[rptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wptr] <= pend_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (fifo_wr) wptr <= wptr + AW'(1);
      if (fifo_rd) rptr <= rptr + AW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (start_ok)             o_overflow <= 1'b0;
      else if (pend && !fifo_wr) o_overflow <= 1'b1;
    end
  end

  assign bus.o_valid = !fifo_empty;
  assign bus.o_byte  = fifo_empty ? 8'h00 : rd_word[7:0];
  assign bus.o_last  = !fifo_empty && rd_word[8];

endmodule
